sdiomux_shifter: RTL and testbench

- Half-duplex bit-serial engine that sits directly upstream of the SDIO mux pad cell.
- Drives the pad cell's O_DAT, O_EN and I_EN, and consumes its I_DAT.
- Converts parallel command words (valid/ready) into timed serial transmit or receive transfers.
- Returns each result on a valid/ready response channel to fabric logic.

---
 rtl/sdiomux_pkg.sv | 17 +
 rtl/sdiomux_sync2.sv | 21 ++
 rtl/sdiomux_shifter.sv | 159 +++++++++++++++
 tb/tb_sdiomux_shifter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdiomux_pkg.sv
// rtl/sdiomux_pkg.sv - shared states and pad constants for the SDIO mux shifter
package sdiomux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;

  localparam logic PAD_EN_ON  = 1'b0;
  localparam logic PAD_EN_OFF = 1'b1;

endpackage

// File: rtl/sdiomux_sync2.sv
// rtl/sdiomux_sync2.sv - two-flop synchronizer for the asynchronous pad input
module sdiomux_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdiomux_shifter.sv
// rtl/sdiomux_shifter.sv - half-duplex serial engine for the SDIO mux pad cell
// Optional even-parity bit: define SDIOMUX_SHIFTER_PARITY_EN.
module sdiomux_shifter
  import sdiomux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DIV_W-1:0] DIV,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_DIR,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_PAR_ERR,
  output logic             BUSY,
  output logic             O_DAT,
  output logic             O_EN,
  output logic             I_EN,
  input  logic             I_DAT
);

`ifdef SDIOMUX_SHIFTER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int SW   = WIDTH + PB;
  localparam int NB_W = $clog2(SW + 1);

  state_t           state, state_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d, pc, pc_d;
  logic [NB_W-1:0]  nb, nb_d;
  logic [SW-1:0]    sreg, sreg_d, tx_word;
  logic [WIDTH-1:0] rsp_data_d;
  logic             rsp_err_d, par_err, sync_dat, accept;
  logic             ready_d, o_en_d, i_en_d, o_dat_d, rsp_valid_d;

  sdiomux_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (I_DAT),
    .q     (sync_dat)
  );

  assign accept = CMD_VALID && CMD_READY;
  assign BUSY   = (state != ST_IDLE);

`ifdef SDIOMUX_SHIFTER_PARITY_EN
  assign tx_word = {CMD_DATA, ^CMD_DATA};
  // RX register holds {data, received parity}; even parity means the XOR over all is 0
  assign par_err = (dir_q == DIR_RX) && (^sreg);
`else
  assign tx_word = CMD_DATA;
  assign par_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (pc == '0 && nb == NB_W'(1)) state_d = ST_GAP;
      ST_GAP:   if (pc == '0) state_d = ST_RESP;
      ST_RESP:  if (RSP_READY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // TX rotates rather than shifts so the sent word is back in place for the echo
  always_comb begin
    sreg_d     = sreg;
    nb_d       = nb;
    pc_d       = pc;
    dir_d      = dir_q;
    div_d      = div_q;
    rsp_data_d = RSP_DATA;
    rsp_err_d  = RSP_PAR_ERR;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          dir_d  = CMD_DIR;
          div_d  = DIV;
          pc_d   = DIV;
          nb_d   = NB_W'(SW);
          sreg_d = (CMD_DIR == DIR_TX) ? tx_word : '0;
        end
      end
      ST_SHIFT: begin
        if (pc == '0) begin
          nb_d   = nb - NB_W'(1);
          pc_d   = div_q;
          sreg_d = (dir_q == DIR_TX) ? {sreg[SW-2:0], sreg[SW-1]}
                                     : {sreg[SW-2:0], sync_dat};
        end else begin
          pc_d = pc - DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (pc == '0) begin
          rsp_data_d = sreg[SW-1 -: WIDTH];
          rsp_err_d  = par_err;
        end else begin
          pc_d = pc - DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Pad-side values are computed from the next state so they register in step with it
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    o_en_d      = (state_d == ST_SHIFT && dir_d == DIR_TX) ? PAD_EN_ON : PAD_EN_OFF;
    i_en_d      = (state_d == ST_SHIFT && dir_d == DIR_RX) ? PAD_EN_ON : PAD_EN_OFF;
    o_dat_d     = (state_d == ST_SHIFT && dir_d == DIR_TX) ? sreg_d[SW-1] : 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dir_q       <= DIR_TX;
      div_q       <= '0;
      pc          <= '0;
      nb          <= '0;
      sreg        <= '0;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_PAR_ERR <= 1'b0;
      O_DAT       <= 1'b0;
      O_EN        <= PAD_EN_OFF;
      I_EN        <= PAD_EN_OFF;
    end else begin
      dir_q       <= dir_d;
      div_q       <= div_d;
      pc          <= pc_d;
      nb          <= nb_d;
      sreg        <= sreg_d;
      CMD_READY   <= ready_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_DATA    <= rsp_data_d;
      RSP_PAR_ERR <= rsp_err_d;
      O_DAT       <= o_dat_d;
      O_EN        <= o_en_d;
      I_EN        <= i_en_d;
    end
  end

endmodule

// File: tb/tb_sdiomux_shifter.sv
// tb/tb_sdiomux_shifter.sv - directed self-checking bench for sdiomux_shifter
// Parity cases are built when SDIOMUX_SHIFTER_PARITY_EN is defined.
module tb_sdiomux_shifter;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;
`ifdef SDIOMUX_SHIFTER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = WIDTH + PB;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [DIV_W-1:0] DIV = '0;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic             CMD_DIR = 1'b0;
  logic [WIDTH-1:0] CMD_DATA = '0;
  logic             RSP_VALID;
  logic             RSP_READY = 1'b0;
  logic [WIDTH-1:0] RSP_DATA;
  logic             RSP_PAR_ERR;
  logic             BUSY;
  logic             O_DAT;
  logic             O_EN;
  logic             I_EN;
  logic             I_DAT = 1'b0;

  int total = 0;
  int bad   = 0;

  sdiomux_shifter #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .DIV         (DIV),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_DIR     (CMD_DIR),
    .CMD_DATA    (CMD_DATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_DATA    (RSP_DATA),
    .RSP_PAR_ERR (RSP_PAR_ERR),
    .BUSY        (BUSY),
    .O_DAT       (O_DAT),
    .O_EN        (O_EN),
    .I_EN        (I_EN),
    .I_DAT       (I_DAT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] tx_seq(input logic [WIDTH-1:0] d);
`ifdef SDIOMUX_SHIFTER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic send_cmd(input logic dir, input logic [WIDTH-1:0] data, input logic [DIV_W-1:0] div);
    int n = 0;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_DIR   = dir;
    CMD_DATA  = data;
    DIV       = div;
    while (!CMD_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("cmd_accept", 32'(CMD_READY), 32'd1);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input logic [WIDTH-1:0] exp_d, input logic exp_e);
    int n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("rsp_data", 32'(RSP_DATA), 32'(exp_d));
    chk("rsp_err", 32'(RSP_PAR_ERR), 32'(exp_e));
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
  endtask

  // Pad bit k must be on I_DAT two edges before the edge that samples it
  task automatic rx_run(input logic [NBITS-1:0] seq, input logic [WIDTH-1:0] exp_d, input logic exp_e);
    int k;
    @(negedge CLK);
    I_DAT = seq[NBITS-1];
    @(negedge CLK);
    I_DAT     = seq[NBITS-2];
    CMD_VALID = 1'b1;
    CMD_DIR   = 1'b1;
    CMD_DATA  = 8'hFF;
    DIV       = '0;
    chk("rx_ready", 32'(CMD_READY), 32'd1);
    for (int j = 1; j <= NBITS + 2; j++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      k = NBITS - 2 - j;
      I_DAT = (k >= 0) ? seq[k] : 1'b0;
      chk("rx_oen", 32'(O_EN), 32'd1);
      if (j <= NBITS) begin
        chk("rx_ien_shift", 32'(I_EN), 32'd0);
      end else if (j == NBITS + 1) begin
        chk("rx_ien_gap", 32'(I_EN), 32'd1);
        chk("rx_early_valid", 32'(RSP_VALID), 32'd0);
      end else begin
        chk("rx_valid", 32'(RSP_VALID), 32'd1);
        chk("rx_data", 32'(RSP_DATA), 32'(exp_d));
        chk("rx_err", 32'(RSP_PAR_ERR), 32'(exp_e));
      end
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [NBITS-1:0] seq;

    repeat (3) @(negedge CLK);
    chk("rst_pads", 32'({O_EN, I_EN, O_DAT}), 32'b110);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_rsp", 32'({RSP_VALID, RSP_PAR_ERR, RSP_DATA}), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_state", 32'({O_EN, I_EN, CMD_READY, BUSY}), 32'b1110);
    end

    // TX 0xA5 at DIV=3; DIV is disturbed after accept and must be ignored
    seq = tx_seq(8'hA5);
    send_cmd(1'b0, 8'hA5, 8'd3);
    DIV = 8'd0;
    for (int i = 1; i <= (NBITS + 1) * 4 + 1; i++) begin
      @(negedge CLK);
      if (i <= NBITS * 4) begin
        chk("tx_oen", 32'(O_EN), 32'd0);
        chk("tx_ien", 32'(I_EN), 32'd1);
        chk("tx_dat", 32'(O_DAT), 32'(seq[NBITS - 1 - (i - 1) / 4]));
        chk("tx_busy", 32'(BUSY), 32'd1);
      end else if (i <= NBITS * 4 + 4) begin
        chk("gap_pads", 32'({O_EN, I_EN, O_DAT}), 32'b110);
      end
      if (i < (NBITS + 1) * 4 + 1) begin
        chk("tx_no_rsp", 32'(RSP_VALID), 32'd0);
      end else begin
        chk("tx_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("tx_rsp_data", 32'(RSP_DATA), 32'h0A5);
      end
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    chk("tx_back_idle", 32'({BUSY, CMD_READY, RSP_VALID}), 32'b010);

`ifdef SDIOMUX_SHIFTER_PARITY_EN
    rx_run({8'h3C, 1'b0}, 8'h3C, 1'b0);
    rx_run({8'h81, 1'b1}, 8'h81, 1'b1);
    rx_run({8'h81, 1'b0}, 8'h81, 1'b0);
`else
    rx_run(8'h3C, 8'h3C, 1'b0);
    rx_run(8'hC5, 8'hC5, 1'b0);
`endif

    // Response backpressure with a second command waiting
    send_cmd(1'b0, 8'h5A, 8'd0);
    begin
      int n = 0;
      while (!RSP_VALID && n < 100) begin
        @(negedge CLK);
        n++;
      end
    end
    CMD_VALID = 1'b1;
    CMD_DIR   = 1'b0;
    CMD_DATA  = 8'h33;
    DIV       = 8'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("bp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp_data", 32'(RSP_DATA), 32'h05A);
      chk("bp_ready", 32'(CMD_READY), 32'd0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    chk("bp_idle", 32'({CMD_READY, BUSY, RSP_VALID}), 32'b100);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("bp_accept", 32'({CMD_READY, BUSY}), 32'b01);
    wait_rsp(8'h33, 1'b0);

    // Reset in the middle of bit 3 of a TX
    send_cmd(1'b0, 8'hFF, 8'd3);
    repeat (13) @(negedge CLK);
    chk("mid_tx_oen", 32'(O_EN), 32'd0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("abort_pads", 32'({O_EN, I_EN, O_DAT}), 32'b110);
    chk("abort_state", 32'({BUSY, RSP_VALID, CMD_READY}), 32'b000);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 32'(CMD_READY), 32'd1);
    send_cmd(1'b0, 8'h96, 8'd1);
    wait_rsp(8'h96, 1'b0);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
